buf_port_arbiter: RTL

BUF_PORT_ARBITER -- requirements
Module: buf_port_arbiter

---
 rtl/buf_arb_pkg.sv | 15 +
 rtl/buf_port_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter.sv | 24 ++
 rtl/buf_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/buf_arb_pkg.sv
// Shared types and constants for the tile-buffer port arbiter.
package buf_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } arb_state_e;

    localparam int unsigned REQ_GEMV = 0;
    localparam int unsigned REQ_RELU = 1;
    localparam int unsigned REQ_LOAD = 2;

    localparam int unsigned BUF_ID_W = 5;

endpackage

// File: rtl/buf_port_arbiter_if.sv
// Requester-side and buffer-side signal bundle of the tile-buffer port arbiter.
interface buf_port_arbiter_if #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TILE_ELEMS = 32
);
    localparam int unsigned ID_W = buf_arb_pkg::BUF_ID_W;

    logic [NUM_REQ-1:0]                                   req_read_en;
    logic [NUM_REQ-1:0][ID_W-1:0]                         req_read_buf_id;
    logic [NUM_REQ-1:0]                                   req_write_en;
    logic [NUM_REQ-1:0][ID_W-1:0]                         req_write_buf_id;
    logic signed [NUM_REQ-1:0][TILE_ELEMS-1:0][DATA_WIDTH-1:0] req_write_tile;
    logic [NUM_REQ-1:0]                                   req_read_valid;
    logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0]         req_read_tile;

    logic                                                 buf_read_enable;
    logic [ID_W-1:0]                                      buf_read_buffer_id;
    logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0]         buf_read_tile;
    logic                                                 buf_read_valid;
    logic                                                 buf_write_enable;
    logic [ID_W-1:0]                                      buf_write_buffer_id;
    logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0]         buf_write_tile;

    // Arbiter view
    modport slave (
        input  req_read_en, req_read_buf_id, req_write_en, req_write_buf_id, req_write_tile,
        input  buf_read_tile, buf_read_valid,
        output req_read_valid, req_read_tile,
        output buf_read_enable, buf_read_buffer_id, buf_write_enable, buf_write_buffer_id,
        output buf_write_tile
    );

    // Requesters plus buffer view
    modport master (
        output req_read_en, req_read_buf_id, req_write_en, req_write_buf_id, req_write_tile,
        output buf_read_tile, buf_read_valid,
        input  req_read_valid, req_read_tile,
        input  buf_read_enable, buf_read_buffer_id, buf_write_enable, buf_write_buffer_id,
        input  buf_write_tile
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or after the start pointer, one-hot out.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[PTR_W'((32'(start) + i) % N)]) begin
                grant[PTR_W'((32'(start) + i) % N)] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buf_port_arbiter.sv
// Arbitrates GEMV/ReLU/LOAD tile reads and writes onto a single buffer port,
// with one outstanding read at a time, read timeout and sticky error flags.
module buf_port_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TILE_ELEMS = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    buf_port_arbiter_if.slave bus,
    input  logic              err_clear,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overflow
);
    import buf_arb_pkg::*;

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_t;
    typedef logic [BUF_ID_W-1:0]                          buf_id_t;

    arb_state_e                state_q, state_d;
    logic [NUM_REQ-1:0]        rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    buf_id_t [NUM_REQ-1:0]     rd_id_q, rd_id_d, wr_id_q, wr_id_d;
    tile_t [NUM_REQ-1:0]       wr_tile_q, wr_tile_d;
    logic [PTR_W-1:0]          last_grant_q, last_grant_d, owner_q, owner_d;
    logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic                      rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    buf_id_t                   rd_bid_q, rd_bid_d, wr_bid_q, wr_bid_d;
    tile_t                     wr_data_q, wr_data_d;
    logic                      busy_q, busy_d;
    logic                      err_tmo_q, err_tmo_d, err_ovf_q, err_ovf_d;

    logic [NUM_REQ-1:0]        rd_eff, wr_eff, req_vec, grant;
    buf_id_t [NUM_REQ-1:0]     rd_id_eff, wr_id_eff;
    tile_t [NUM_REQ-1:0]       wr_tile_eff;
    logic                      ovf_evt, tmo_evt, rsp_hit;
    logic [PTR_W-1:0]          start_ptr, sel;

    // Slot view including this cycle's pulses; a pulse onto a full slot is dropped
    always_comb begin
        rd_eff      = rd_pend_q;
        wr_eff      = wr_pend_q;
        rd_id_eff   = rd_id_q;
        wr_id_eff   = wr_id_q;
        wr_tile_eff = wr_tile_q;
        ovf_evt     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_read_en[i]) begin
                if (rd_pend_q[i]) begin
                    ovf_evt = 1'b1;
                end else begin
                    rd_eff[i]    = 1'b1;
                    rd_id_eff[i] = bus.req_read_buf_id[i];
                end
            end
            if (bus.req_write_en[i]) begin
                if (wr_pend_q[i]) begin
                    ovf_evt = 1'b1;
                end else begin
                    wr_eff[i]      = 1'b1;
                    wr_id_eff[i]   = bus.req_write_buf_id[i];
                    wr_tile_eff[i] = bus.req_write_tile[i];
                end
            end
        end
    end

    assign req_vec   = rd_eff | wr_eff;
    assign start_ptr = (last_grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : last_grant_q + PTR_W'(1);

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req_vec),
        .start (start_ptr),
        .grant (grant)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel = PTR_W'(i);
        end
    end

    // Next-state: grant in IDLE (write before read), wait/timeout in READ_WAIT
    always_comb begin
        state_d      = state_q;
        rd_pend_d    = rd_eff;
        wr_pend_d    = wr_eff;
        rd_id_d      = rd_id_eff;
        wr_id_d      = wr_id_eff;
        wr_tile_d    = wr_tile_eff;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wait_cnt_d   = wait_cnt_q;
        rd_en_d      = 1'b0;
        rd_bid_d     = '0;
        wr_en_d      = 1'b0;
        wr_bid_d     = '0;
        wr_data_d    = '0;
        tmo_evt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    last_grant_d = sel;
                    if (wr_eff[sel]) begin
                        wr_en_d        = 1'b1;
                        wr_bid_d       = wr_id_eff[sel];
                        wr_data_d      = wr_tile_eff[sel];
                        wr_pend_d[sel] = 1'b0;
                    end else begin
                        rd_en_d        = 1'b1;
                        rd_bid_d       = rd_id_eff[sel];
                        rd_pend_d[sel] = 1'b0;
                        owner_d        = sel;
                        wait_cnt_d     = '0;
                        state_d        = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (bus.buf_read_valid) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_evt = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (|rd_pend_d) | (|wr_pend_d) | (state_d == READ_WAIT);
        err_tmo_d = (err_tmo_q & ~err_clear) | tmo_evt;
        err_ovf_d = (err_ovf_q & ~err_clear) | ovf_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_pend_q    <= '0;
            wr_pend_q    <= '0;
            rd_id_q      <= '0;
            wr_id_q      <= '0;
            wr_tile_q    <= '0;
            last_grant_q <= PTR_W'(NUM_REQ - 1);
            owner_q      <= '0;
            wait_cnt_q   <= '0;
            rd_en_q      <= 1'b0;
            rd_bid_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_bid_q     <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            err_tmo_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= rd_pend_d;
            wr_pend_q    <= wr_pend_d;
            rd_id_q      <= rd_id_d;
            wr_id_q      <= wr_id_d;
            wr_tile_q    <= wr_tile_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            rd_en_q      <= rd_en_d;
            rd_bid_q     <= rd_bid_d;
            wr_en_q      <= wr_en_d;
            wr_bid_q     <= wr_bid_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            err_tmo_q    <= err_tmo_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    // Read data passes straight through to the owner while a read is outstanding
    always_comb begin
        rsp_hit            = (state_q == READ_WAIT) && bus.buf_read_valid;
        bus.req_read_tile  = rsp_hit ? bus.buf_read_tile : '0;
        bus.req_read_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_read_valid[i] = rsp_hit && (owner_q == PTR_W'(i));
        end
    end

    assign bus.buf_read_enable     = rd_en_q;
    assign bus.buf_read_buffer_id  = rd_bid_q;
    assign bus.buf_write_enable    = wr_en_q;
    assign bus.buf_write_buffer_id = wr_bid_q;
    assign bus.buf_write_tile      = wr_data_q;
    assign busy                    = busy_q;
    assign err_timeout             = err_tmo_q;
    assign err_overflow            = err_ovf_q;

endmodule
